// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - Load/store memory pipeline stage with a single-outstanding bus handshake
module mem_stage #(
  parameter int MISALIGN_CHK = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        lsu_en_mem,
  input  logic        lsu_op_mem,
  input  logic [2:0]  lsu_dtype_mem,
  input  logic [31:0] lsu_addr_mem,
  input  logic [31:0] lsu_wdata_mem,
  input  logic        rd_wr_en_mem,
  input  logic [4:0]  rd_wr_addr_mem,
  input  logic [31:0] rd_wr_data_mem,
  input  logic [31:0] pc_mem,
  input  logic        flush_M,
  input  logic        ready_wb,
  output logic        ready_mem,
  output logic        data_req,
  input  logic        data_gnt,
  output logic [31:0] data_addr,
  output logic        data_we,
  output logic [3:0]  data_be,
  output logic [31:0] data_wdata,
  input  logic        data_rvalid,
  input  logic [31:0] data_rdata,
  output logic        rd_wr_en_wb,
  output logic [4:0]  rd_wr_addr_wb,
  output logic [31:0] rd_wr_data_wb,
  output logic [31:0] pc_wb,
  output logic        misalign_exc
);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID} state_t;
  state_t state, state_nxt;

  logic [1:0]  off_raw, off_eff, off_q;
  logic        mis_raw, misaligned;
  logic [3:0]  be_calc, be_q;
  logic [31:0] wdata_calc, wdata_q, addr_q, pc_q;
  logic [2:0]  dtype_q;
  logic        we_q, rd_en_q, kill_q;
  logic [4:0]  rd_addr_q;
  logic        hold_q, hold_wen_q;
  logic [31:0] hold_data_q;
  logic [31:0] shifted, load_data;
  logic        issue, capture_hold;
  logic        wb_en_nxt;
  logic [4:0]  wb_addr_nxt;
  logic [31:0] wb_data_nxt, wb_pc_nxt;

  assign off_raw    = lsu_addr_mem[1:0];
  assign mis_raw    = ((lsu_dtype_mem[1:0] == 2'b01) && off_raw[0]) ||
                      ((lsu_dtype_mem == 3'b010) && (off_raw != 2'b00));
  assign misaligned = (MISALIGN_CHK != 0) && lsu_en_mem && mis_raw;
  // With checking disabled a misaligned access is issued as if word-aligned.
  assign off_eff    = (mis_raw && (MISALIGN_CHK == 0)) ? 2'b00 : off_raw;

  always_comb begin
    be_calc = 4'b1111;
    case (lsu_dtype_mem[1:0])
      2'b00:   be_calc = 4'b0001 << off_eff;
      2'b01:   be_calc = 4'b0011 << off_eff;
      default: be_calc = 4'b1111;
    endcase
  end

  assign wdata_calc = lsu_wdata_mem << {off_eff, 3'b000};
  assign shifted    = data_rdata >> {off_q, 3'b000};

  always_comb begin
    load_data = shifted;
    case (dtype_q)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_data = {24'd0, shifted[7:0]};
      3'b101:  load_data = {16'd0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  always_comb begin
    state_nxt    = state;
    data_req     = 1'b0;
    data_addr    = 32'd0;
    data_we      = 1'b0;
    data_be      = 4'd0;
    data_wdata   = 32'd0;
    ready_mem    = 1'b0;
    misalign_exc = 1'b0;
    issue        = 1'b0;
    capture_hold = 1'b0;
    wb_en_nxt    = 1'b0;
    wb_addr_nxt  = rd_wr_addr_mem;
    wb_data_nxt  = rd_wr_data_mem;
    wb_pc_nxt    = pc_mem;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (hold_q) begin
            // A completion parked while WB stalled; EX still presents that instruction.
            ready_mem   = ready_wb;
            wb_en_nxt   = hold_wen_q;
            wb_addr_nxt = rd_addr_q;
            wb_data_nxt = hold_data_q;
            wb_pc_nxt   = pc_q;
          end else if (lsu_en_mem && !flush_M && !misaligned) begin
            issue      = 1'b1;
            data_req   = 1'b1;
            data_addr  = {lsu_addr_mem[31:2], 2'b00};
            data_we    = lsu_op_mem;
            data_be    = be_calc;
            data_wdata = wdata_calc;
            state_nxt  = data_gnt ? WAIT_RVALID : WAIT_GNT;
          end else begin
            ready_mem    = ready_wb;
            misalign_exc = misaligned && !flush_M && ready_wb;
            wb_en_nxt    = rd_wr_en_mem && !flush_M && !misaligned;
          end
        end
        WAIT_GNT: begin
          data_req   = 1'b1;
          data_addr  = addr_q;
          data_we    = we_q;
          data_be    = be_q;
          data_wdata = wdata_q;
          if (data_gnt) state_nxt = WAIT_RVALID;
        end
        WAIT_RVALID: begin
          data_addr  = addr_q;
          data_we    = we_q;
          data_be    = be_q;
          data_wdata = wdata_q;
          if (data_rvalid) begin
            state_nxt   = IDLE;
            wb_en_nxt   = rd_en_q && !we_q && !kill_q && !flush_M;
            wb_addr_nxt = rd_addr_q;
            wb_data_nxt = we_q ? rd_wr_data_mem : load_data;
            wb_pc_nxt   = pc_q;
            if (ready_wb) ready_mem = 1'b1;
            else          capture_hold = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      kill_q        <= 1'b0;
      hold_q        <= 1'b0;
      hold_wen_q    <= 1'b0;
      hold_data_q   <= 32'd0;
      addr_q        <= 32'd0;
      we_q          <= 1'b0;
      be_q          <= 4'd0;
      wdata_q       <= 32'd0;
      dtype_q       <= 3'd0;
      off_q         <= 2'd0;
      rd_en_q       <= 1'b0;
      rd_addr_q     <= 5'd0;
      pc_q          <= 32'd0;
      rd_wr_en_wb   <= 1'b0;
      rd_wr_addr_wb <= 5'd0;
      rd_wr_data_wb <= 32'd0;
      pc_wb         <= 32'd0;
    end else begin
      state <= state_nxt;
      if (issue) begin
        addr_q    <= {lsu_addr_mem[31:2], 2'b00};
        we_q      <= lsu_op_mem;
        be_q      <= be_calc;
        wdata_q   <= wdata_calc;
        dtype_q   <= lsu_dtype_mem;
        off_q     <= off_eff;
        rd_en_q   <= rd_wr_en_mem;
        rd_addr_q <= rd_wr_addr_mem;
        pc_q      <= pc_mem;
      end
      if (state_nxt == IDLE)                   kill_q <= 1'b0;
      else if (state != IDLE && flush_M)       kill_q <= 1'b1;
      if (capture_hold) begin
        hold_q      <= 1'b1;
        hold_wen_q  <= wb_en_nxt;
        hold_data_q <= wb_data_nxt;
      end else if (state == IDLE && hold_q && ready_wb) begin
        hold_q <= 1'b0;
      end
      if (ready_mem) begin
        rd_wr_en_wb   <= wb_en_nxt;
        rd_wr_addr_wb <= wb_addr_nxt;
        rd_wr_data_wb <= wb_data_nxt;
        pc_wb         <= wb_pc_nxt;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - Directed vector and sequence bench for mem_stage
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset, lsu_en_mem, lsu_op_mem, rd_wr_en_mem, flush_M, ready_wb;
  logic [2:0]  lsu_dtype_mem;
  logic [31:0] lsu_addr_mem, lsu_wdata_mem, rd_wr_data_mem, pc_mem, data_rdata;
  logic [4:0]  rd_wr_addr_mem;
  logic        ready_mem, data_req, data_gnt, data_we, data_rvalid;
  logic [31:0] data_addr, data_wdata, rd_wr_data_wb, pc_wb;
  logic [3:0]  data_be;
  logic        rd_wr_en_wb, misalign_exc;
  logic [4:0]  rd_wr_addr_wb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage #(.MISALIGN_CHK(1)) dut (
    .clk(clk), .reset(reset), .lsu_en_mem(lsu_en_mem), .lsu_op_mem(lsu_op_mem),
    .lsu_dtype_mem(lsu_dtype_mem), .lsu_addr_mem(lsu_addr_mem), .lsu_wdata_mem(lsu_wdata_mem),
    .rd_wr_en_mem(rd_wr_en_mem), .rd_wr_addr_mem(rd_wr_addr_mem), .rd_wr_data_mem(rd_wr_data_mem),
    .pc_mem(pc_mem), .flush_M(flush_M), .ready_wb(ready_wb), .ready_mem(ready_mem),
    .data_req(data_req), .data_gnt(data_gnt), .data_addr(data_addr), .data_we(data_we),
    .data_be(data_be), .data_wdata(data_wdata), .data_rvalid(data_rvalid), .data_rdata(data_rdata),
    .rd_wr_en_wb(rd_wr_en_wb), .rd_wr_addr_wb(rd_wr_addr_wb), .rd_wr_data_wb(rd_wr_data_wb),
    .pc_wb(pc_wb), .misalign_exc(misalign_exc)
  );

  typedef struct {
    logic        en;
    logic        op;
    logic [2:0]  dt;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rd_en;
    logic [4:0]  rd;
    logic [31:0] rd_data;
    logic [31:0] pc;
    logic [31:0] rdata;
    logic        req;
    logic [3:0]  be;
    logic [31:0] xwdata;
    logic        mis;
    logic        wb_en;
    logic [31:0] wb_data;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive_vec(input vec_t v);
    lsu_en_mem     = v.en;
    lsu_op_mem     = v.op;
    lsu_dtype_mem  = v.dt;
    lsu_addr_mem   = v.addr;
    lsu_wdata_mem  = v.wdata;
    rd_wr_en_mem   = v.rd_en;
    rd_wr_addr_mem = v.rd;
    rd_wr_data_mem = v.rd_data;
    pc_mem         = v.pc;
  endtask

  task automatic go_idle();
    lsu_en_mem   = 1'b0;
    rd_wr_en_mem = 1'b0;
    data_gnt     = 1'b0;
    data_rvalid  = 1'b0;
    flush_M      = 1'b0;
    ready_wb     = 1'b1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", idx);
    drive_vec(v);
    ready_wb    = 1'b1;
    data_gnt    = v.req;
    data_rvalid = 1'b0;
    settle();
    chk({tag, "_ready_mem"}, ready_mem, !v.req);
    chk({tag, "_data_req"}, data_req, v.req);
    chk({tag, "_misalign"}, misalign_exc, v.mis);
    if (v.req) begin
      chk({tag, "_addr"}, data_addr, {v.addr[31:2], 2'b00});
      chk({tag, "_be"}, data_be, v.be);
      chk({tag, "_wdata"}, data_wdata, v.xwdata);
      chk({tag, "_we"}, data_we, v.op);
      step();
      data_gnt    = 1'b0;
      data_rvalid = 1'b1;
      data_rdata  = v.rdata;
      settle();
      chk({tag, "_rsp_ready"}, ready_mem, 1'b1);
      chk({tag, "_rsp_req"}, data_req, 1'b0);
    end
    step();
    data_rvalid = 1'b0;
    chk({tag, "_wb_en"}, rd_wr_en_wb, v.wb_en);
    chk({tag, "_wb_data"}, rd_wr_data_wb, v.wb_data);
    chk({tag, "_wb_pc"}, pc_wb, v.pc);
    if (v.wb_en) chk({tag, "_wb_rd"}, rd_wr_addr_wb, v.rd);
    go_idle();
  endtask

  initial begin
    vec_t v;
    //          en   op   dt      addr          wdata          rd_en rd     rd_data        pc         rdata          req  be       xwdata         mis  wb_en wb_data
    vecs[0]  = '{1'b0,1'b0,3'b000,32'h0,        32'h0,         1'b1,5'd3, 32'h11112222, 32'h100, 32'h0,         1'b0,4'b0000,32'h0,         1'b0,1'b1, 32'h11112222};
    vecs[1]  = '{1'b1,1'b0,3'b000,32'h1003,     32'h0,         1'b1,5'd4, 32'h0,        32'h104, 32'h80AABBCC,  1'b1,4'b1000,32'h0,         1'b0,1'b1, 32'hFFFFFF80};
    vecs[2]  = '{1'b1,1'b0,3'b100,32'h1003,     32'h0,         1'b1,5'd4, 32'h0,        32'h108, 32'h80AABBCC,  1'b1,4'b1000,32'h0,         1'b0,1'b1, 32'h00000080};
    vecs[3]  = '{1'b1,1'b1,3'b001,32'h2002,     32'h1234ABCD,  1'b1,5'd2, 32'h77,       32'h10C, 32'h0,         1'b1,4'b1100,32'hABCD0000,  1'b0,1'b0, 32'h77};
    vecs[4]  = '{1'b1,1'b0,3'b010,32'h3001,     32'h0,         1'b1,5'd5, 32'h55,       32'h110, 32'h0,         1'b0,4'b0000,32'h0,         1'b1,1'b0, 32'h55};
    vecs[5]  = '{1'b1,1'b0,3'b001,32'h4002,     32'h0,         1'b1,5'd6, 32'h0,        32'h114, 32'h80011234,  1'b1,4'b1100,32'h0,         1'b0,1'b1, 32'hFFFF8001};
    vecs[6]  = '{1'b1,1'b0,3'b101,32'h4002,     32'h0,         1'b1,5'd6, 32'h0,        32'h118, 32'h80011234,  1'b1,4'b1100,32'h0,         1'b0,1'b1, 32'h00008001};
    vecs[7]  = '{1'b1,1'b0,3'b000,32'h10,       32'h0,         1'b1,5'd7, 32'h0,        32'h11C, 32'h1234567F,  1'b1,4'b0001,32'h0,         1'b0,1'b1, 32'h0000007F};
    vecs[8]  = '{1'b1,1'b1,3'b000,32'h5001,     32'h000000AB,  1'b0,5'd0, 32'h99,       32'h120, 32'h0,         1'b1,4'b0010,32'h0000AB00,  1'b0,1'b0, 32'h99};
    vecs[9]  = '{1'b1,1'b1,3'b010,32'h6000,     32'hCAFEF00D,  1'b0,5'd0, 32'h0,        32'h124, 32'h0,         1'b1,4'b1111,32'hCAFEF00D,  1'b0,1'b0, 32'h0};
    vecs[10] = '{1'b1,1'b0,3'b001,32'h7001,     32'h0,         1'b1,5'd9, 32'hA1,       32'h128, 32'h0,         1'b0,4'b0000,32'h0,         1'b1,1'b0, 32'hA1};
    vecs[11] = '{1'b1,1'b1,3'b010,32'h6002,     32'h1,         1'b0,5'd0, 32'hB2,       32'h12C, 32'h0,         1'b0,4'b0000,32'h0,         1'b1,1'b0, 32'hB2};
    vecs[12] = '{1'b0,1'b0,3'b000,32'h0,        32'h0,         1'b0,5'd1, 32'h33,       32'h130, 32'h0,         1'b0,4'b0000,32'h0,         1'b0,1'b0, 32'h33};
    vecs[13] = '{1'b1,1'b0,3'b010,32'h8004,     32'h0,         1'b1,5'd8, 32'h0,        32'h134, 32'hDEADBEEF,  1'b1,4'b1111,32'h0,         1'b0,1'b1, 32'hDEADBEEF};
    vecs[14] = '{1'b1,1'b0,3'b000,32'h20001,    32'h0,         1'b1,5'd10,32'h0,        32'h138, 32'h0000FE00,  1'b1,4'b0010,32'h0,         1'b0,1'b1, 32'hFFFFFFFE};

    // Reset with a live aligned request on the inputs
    reset = 1'b1;
    go_idle();
    data_rdata = 32'h0;
    v = vecs[13];
    drive_vec(v);
    step();
    step();
    settle();
    chk("rst_data_req", data_req, 1'b0);
    chk("rst_data_we", data_we, 1'b0);
    chk("rst_data_be", data_be, 4'd0);
    chk("rst_data_addr", data_addr, 32'd0);
    chk("rst_misalign", misalign_exc, 1'b0);
    chk("rst_wb_en", rd_wr_en_wb, 1'b0);
    chk("rst_wb_rd", rd_wr_addr_wb, 5'd0);
    chk("rst_wb_data", rd_wr_data_wb, 32'd0);
    chk("rst_wb_pc", pc_wb, 32'd0);
    go_idle();
    reset = 1'b0;
    step();

    for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

    // Grant withheld for three cycles; EX address changes but bus outputs must not
    v = '{1'b1,1'b0,3'b010,32'h9008,32'h0,1'b1,5'd7,32'h0,32'h1E0,32'h01020304,1'b1,4'b1111,32'h0,1'b0,1'b1,32'h01020304};
    drive_vec(v);
    data_gnt = 1'b0;
    settle();
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("gnt_wait%0d_req", c), data_req, 1'b1);
      chk($sformatf("gnt_wait%0d_addr", c), data_addr, 32'h9008);
      chk($sformatf("gnt_wait%0d_be", c), data_be, 4'b1111);
      chk($sformatf("gnt_wait%0d_we", c), data_we, 1'b0);
      chk($sformatf("gnt_wait%0d_ready", c), ready_mem, 1'b0);
      step();
      lsu_addr_mem = 32'hFFFF_FFF3;
      settle();
    end
    data_gnt = 1'b1;
    settle();
    chk("gnt_late_req", data_req, 1'b1);
    chk("gnt_late_addr", data_addr, 32'h9008);
    step();
    data_gnt    = 1'b0;
    data_rvalid = 1'b1;
    data_rdata  = 32'h01020304;
    settle();
    chk("gnt_late_ready", ready_mem, 1'b1);
    step();
    data_rvalid = 1'b0;
    chk("gnt_late_wb_data", rd_wr_data_wb, 32'h01020304);
    chk("gnt_late_wb_rd", rd_wr_addr_wb, 5'd7);
    go_idle();

    // Flush while waiting for the response: transaction completes as a bubble
    v = '{1'b1,1'b0,3'b010,32'hA000,32'h0,1'b1,5'd5,32'h0,32'h1F0,32'h0,1'b1,4'b1111,32'h0,1'b0,1'b1,32'h0};
    drive_vec(v);
    data_gnt = 1'b1;
    settle();
    step();
    data_gnt = 1'b0;
    flush_M  = 1'b1;
    settle();
    chk("flush_wait_req", data_req, 1'b0);
    chk("flush_wait_ready", ready_mem, 1'b0);
    step();
    flush_M     = 1'b0;
    data_rvalid = 1'b1;
    data_rdata  = 32'h5555;
    settle();
    chk("flush_rsp_ready", ready_mem, 1'b1);
    step();
    data_rvalid = 1'b0;
    chk("flush_wb_en", rd_wr_en_wb, 1'b0);
    go_idle();
    v = '{1'b1,1'b0,3'b010,32'hA004,32'h0,1'b1,5'd6,32'h0,32'h200,32'h600D600D,1'b1,4'b1111,32'h0,1'b0,1'b1,32'h600D600D};
    run_vec(100, v);

    // Response arrives while WB is stalled
    v = '{1'b1,1'b0,3'b010,32'hB000,32'h0,1'b1,5'd9,32'h0,32'h300,32'h0,1'b1,4'b1111,32'h0,1'b0,1'b1,32'h0};
    drive_vec(v);
    data_gnt = 1'b1;
    settle();
    step();
    data_gnt    = 1'b0;
    data_rvalid = 1'b1;
    data_rdata  = 32'hDEADBEEF;
    ready_wb    = 1'b0;
    settle();
    chk("stall_rsp_ready", ready_mem, 1'b0);
    step();
    data_rvalid = 1'b0;
    data_rdata  = 32'h0;
    settle();
    chk("stall_hold_req", data_req, 1'b0);
    chk("stall_hold_ready", ready_mem, 1'b0);
    chk("stall_hold_wb_data", rd_wr_data_wb, 32'h600D600D);
    chk("stall_hold_wb_rd", rd_wr_addr_wb, 5'd6);
    step();
    ready_wb = 1'b1;
    settle();
    chk("stall_release_ready", ready_mem, 1'b1);
    chk("stall_release_req", data_req, 1'b0);
    step();
    chk("stall_wb_data", rd_wr_data_wb, 32'hDEADBEEF);
    chk("stall_wb_en", rd_wr_en_wb, 1'b1);
    chk("stall_wb_rd", rd_wr_addr_wb, 5'd9);
    chk("stall_wb_pc", pc_wb, 32'h300);
    go_idle();

    // Reset mid-transaction, then a stale response must be ignored
    v = '{1'b1,1'b0,3'b010,32'hC000,32'h0,1'b1,5'd11,32'h0,32'h400,32'h0,1'b1,4'b1111,32'h0,1'b0,1'b1,32'h0};
    drive_vec(v);
    data_gnt = 1'b1;
    settle();
    step();
    data_gnt = 1'b0;
    reset    = 1'b1;
    step();
    reset          = 1'b0;
    lsu_en_mem     = 1'b0;
    rd_wr_en_mem   = 1'b0;
    rd_wr_data_mem = 32'h44;
    data_rvalid    = 1'b1;
    data_rdata     = 32'h12345678;
    settle();
    chk("stale_req", data_req, 1'b0);
    chk("stale_ready", ready_mem, 1'b1);
    step();
    data_rvalid = 1'b0;
    chk("stale_wb_en", rd_wr_en_wb, 1'b0);
    chk("stale_wb_data", rd_wr_data_wb, 32'h44);
    drive_vec(v);
    settle();
    chk("post_rst_req", data_req, 1'b1);
    step();
    settle();
    chk("post_rst_wait_gnt_req", data_req, 1'b1);
    data_gnt = 1'b1;
    step();
    data_gnt    = 1'b0;
    data_rvalid = 1'b1;
    data_rdata  = 32'h00000005;
    step();
    data_rvalid = 1'b0;
    chk("post_rst_wb_data", rd_wr_data_wb, 32'h5);
    chk("post_rst_wb_rd", rd_wr_addr_wb, 5'd11);
    go_idle();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
